bsg_tanh_sched: RTL

BSG_TANH_SCHED -- requirements
Module: bsg_tanh_sched

---
 rtl/bsg_tanh_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bsg_tanh_sched.sv
// Round-robin scheduler sharing one tanh unit among els_p requesters, one operation in flight.
// Unit results that arrive outside eWAIT (e.g. after a timeout) are consumed and dropped.
module bsg_tanh_sched #(
  parameter int unsigned els_p       = 4,
  parameter int unsigned ang_width_p = 21,
  parameter int unsigned ans_width_p = 32,
  parameter int unsigned timeout_p   = 255
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  logic [els_p-1:0]               v_i,
  input  logic [els_p*ang_width_p-1:0]   ang_i,
  output logic [els_p-1:0]               ready_o,

  output logic                           v_o,
  output logic [ans_width_p-1:0]         tanh_o,
  output logic [$clog2(els_p)-1:0]       id_o,
  output logic                           err_o,
  input  logic                           ready_i,

  output logic                           unit_v_o,
  output logic [ang_width_p-1:0]         unit_ang_o,
  input  logic                           unit_ready_i,

  input  logic                           unit_v_i,
  input  logic [ans_width_p-1:0]         unit_tanh_i,
  output logic                           unit_yumi_o,

  output logic [15:0]                    done_cnt_o
);

  localparam int unsigned id_width_lp  = $clog2(els_p);
  localparam int unsigned cnt_width_lp = $clog2(timeout_p + 1);
  localparam logic [id_width_lp:0]    els_lp     = (id_width_lp + 1)'(els_p);
  localparam logic [id_width_lp-1:0]  last_id_lp = id_width_lp'(els_p - 1);
  // Counter value on the last waiting cycle; the timeout fires as it would reach timeout_p.
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(timeout_p - 1);

  typedef enum logic [1:0] {eIDLE, eISSUE, eWAIT, eRESP} state_e;

  state_e                   state_q, state_d;
  logic [id_width_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [id_width_lp-1:0]   id_q, id_d;
  logic [ang_width_p-1:0]   ang_q, ang_d;
  logic [ans_width_p-1:0]   tanh_q, tanh_d;
  logic                     err_q, err_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic [15:0]              done_q, done_d;

  logic                     gnt_v;
  logic [id_width_lp-1:0]   gnt_id;

  // First valid requester at or above rr_ptr, wrapping modulo els_p.
  always_comb begin
    logic [id_width_lp:0] idx;
    gnt_v  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int unsigned k = 0; k < els_p; k++) begin
      idx = {1'b0, rr_ptr_q} + (id_width_lp + 1)'(k);
      if (idx >= els_lp) idx = idx - els_lp;
      if (!gnt_v && v_i[idx[id_width_lp-1:0]]) begin
        gnt_v  = 1'b1;
        gnt_id = idx[id_width_lp-1:0];
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (reset_n_i && (state_q == eIDLE) && gnt_v) ready_o[gnt_id] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    ang_d    = ang_q;
    tanh_d   = tanh_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    unique case (state_q)
      eIDLE: begin
        if (gnt_v) begin
          ang_d    = ang_i[gnt_id*ang_width_p +: ang_width_p];
          id_d     = gnt_id;
          rr_ptr_d = (gnt_id == last_id_lp) ? '0 : gnt_id + 1'b1;
          state_d  = eISSUE;
        end
      end
      eISSUE: begin
        if (unit_ready_i) begin
          cnt_d   = '0;
          state_d = eWAIT;
        end
      end
      eWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (unit_v_i) begin
          tanh_d  = unit_tanh_i;
          err_d   = 1'b0;
          state_d = eRESP;
        end else if (cnt_q == last_cnt_lp) begin
          tanh_d  = '0;
          err_d   = 1'b1;
          state_d = eRESP;
        end
      end
      eRESP: begin
        if (ready_i) begin
          done_d  = done_q + 16'd1;
          state_d = eIDLE;
        end
      end
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= eIDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      ang_q    <= '0;
      tanh_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      ang_q    <= ang_d;
      tanh_q   <= tanh_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign v_o         = (state_q == eRESP);
  assign tanh_o      = tanh_q;
  assign id_o        = id_q;
  assign err_o       = err_q;
  assign unit_v_o    = (state_q == eISSUE);
  assign unit_ang_o  = ang_q;
  // Always accept: in eWAIT the result is captured, anywhere else it is stale.
  assign unit_yumi_o = unit_v_i;
  assign done_cnt_o  = done_q;

endmodule
